// File: rtl/check_seq_pkg.sv
// check_seq_pkg: state encoding, sequence geometry and level clamp shared by the sequence checker.
package check_seq_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_IN, RESULT} state_t;
    localparam int MAX_DIGITS = 5;
    localparam int DIGIT_W = 4;
    localparam int SEQ_W = MAX_DIGITS * DIGIT_W;
    localparam int IDX_W = 3;
    // A level of 0 still checks one digit; anything above the sequence length checks all of it.
    function automatic logic [IDX_W-1:0] clamp_lvl(input logic [IDX_W-1:0] lvl);
        return (lvl == '0) ? IDX_W'(1) : (lvl > IDX_W'(MAX_DIGITS)) ? IDX_W'(MAX_DIGITS) : lvl;
    endfunction
endpackage

// File: rtl/input_timer.sv
// input_timer: saturating per-digit timeout counter, flags expiry while enabled.
module input_timer #(
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic expired
);
    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (restart) cnt <= '0;
        else if (enable && cnt != LAST) cnt <= cnt + 1'b1;
    assign expired = enable && cnt == LAST;
endmodule

// File: rtl/check_seq.sv
// check_seq: compares player key presses against a latched digit sequence with a per-digit timeout.
module check_seq
    import check_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               check,
    input  logic [IDX_W-1:0]   curLvl,
    input  logic [SEQ_W-1:0]   seq,
    input  logic               btnValid,
    input  logic [DIGIT_W-1:0] btnDigit,
    output logic               waiting,
    output logic [IDX_W-1:0]   digitIdx,
    output logic               checkDone,
    output logic               pass,
    output logic               fail
);
    state_t state, state_nx;
    logic [SEQ_W-1:0] seq_q, seq_nx;
    logic [IDX_W-1:0] lvl_q, lvl_nx, idx_q, idx_nx;
    logic pass_q, pass_nx, fail_q, fail_nx;
    logic restart, expired, hit, last;
    assign hit = btnDigit == seq_q[DIGIT_W*idx_q +: DIGIT_W];
    assign last = idx_q == lvl_q - 3'd1;
    input_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (state == WAIT_IN),
        .restart(restart),
        .expired(expired)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state  <= IDLE;
            seq_q  <= '0;
            lvl_q  <= '0;
            idx_q  <= '0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            state  <= state_nx;
            seq_q  <= seq_nx;
            lvl_q  <= lvl_nx;
            idx_q  <= idx_nx;
            pass_q <= pass_nx;
            fail_q <= fail_nx;
        end
    // A key press in the same cycle as expiry is evaluated first; expiry only applies without one.
    always_comb begin
        state_nx = state;
        seq_nx   = seq_q;
        lvl_nx   = lvl_q;
        idx_nx   = idx_q;
        pass_nx  = pass_q;
        fail_nx  = fail_q;
        restart  = 1'b0;
        case (state)
            IDLE: if (check) begin
                seq_nx   = seq;
                lvl_nx   = clamp_lvl(curLvl);
                idx_nx   = '0;
                pass_nx  = 1'b0;
                fail_nx  = 1'b0;
                restart  = 1'b1;
                state_nx = WAIT_IN;
            end
            WAIT_IN: if (btnValid) begin
                if (!hit) begin
                    fail_nx  = 1'b1;
                    state_nx = RESULT;
                end else if (last) begin
                    pass_nx  = 1'b1;
                    state_nx = RESULT;
                end else begin
                    idx_nx  = idx_q + 3'd1;
                    restart = 1'b1;
                end
            end else if (expired) begin
                fail_nx  = 1'b1;
                state_nx = RESULT;
            end
            RESULT: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    assign waiting   = state == WAIT_IN;
    assign checkDone = state == RESULT;
    assign digitIdx  = idx_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
endmodule

// File: tb/tb_check_seq.sv
// tb_check_seq: directed and randomized checks of check_seq against a verdict-level reference model.
module tb_check_seq;
    localparam int T = 100;
    logic clk = 1'b0;
    logic rst, check, btn_valid;
    logic [2:0] cur_lvl;
    logic [19:0] seq_i;
    logic [3:0] btn_digit;
    logic waiting, check_done, pass, fail;
    logic [2:0] digit_idx;
    int cyc = 0;
    int done_cnt = 0;
    int checks = 0;
    int errors = 0;
    int base;
    logic [3:0] kd[5];
    int kg[5];

    check_seq #(.TIMEOUT_CYCLES(T)) dut (
        .clk      (clk),
        .rst      (rst),
        .check    (check),
        .curLvl   (cur_lvl),
        .seq      (seq_i),
        .btnValid (btn_valid),
        .btnDigit (btn_digit),
        .waiting  (waiting),
        .digitIdx (digit_idx),
        .checkDone(check_done),
        .pass     (pass),
        .fail     (fail)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) if (check_done) done_cnt++;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_keys(input logic [3:0] a, b, c, d, e, input int g);
        kd[0] = a; kd[1] = b; kd[2] = c; kd[3] = d; kd[4] = e;
        for (int i = 0; i < 5; i++) kg[i] = g;
    endtask

    // Runs one check from a negedge; the model derives verdict, verdict cycle and index from the key plan.
    task automatic do_check(input logic [19:0] s, input logic [2:0] lv, input int nk, input bit mid, input string tag);
        int el, prev, idx, v, eidx, b0;
        bit ep, ef, decided;
        logic [19:0] sh;
        el = (lv == 0) ? 1 : (lv > 5) ? 5 : int'(lv);
        b0 = done_cnt;
        ep = 0; ef = 0; decided = 0; idx = 0; v = 0; eidx = 0;
        seq_i = s; cur_lvl = lv; check = 1'b1;
        @(negedge clk);
        prev = cyc;
        check = 1'b0;
        seq_i = 20'($urandom);
        cur_lvl = 3'($urandom);
        chk({tag, "_start_waiting"}, 32'(waiting), 1);
        chk({tag, "_start_idx"}, 32'(digit_idx), 0);
        chk({tag, "_start_pass"}, 32'(pass), 0);
        chk({tag, "_start_fail"}, 32'(fail), 0);
        for (int i = 0; i < nk && !decided; i++) begin
            if (kg[i] > T) begin
                v = prev + T; ef = 1; eidx = idx; decided = 1;
            end else begin
                repeat (kg[i] - 1) @(negedge clk);
                btn_valid = 1'b1;
                btn_digit = kd[i];
                if (mid && i == 1) begin
                    check = 1'b1;
                    seq_i = 20'($urandom);
                    cur_lvl = 3'($urandom);
                end
                @(negedge clk);
                btn_valid = 1'b0;
                check = 1'b0;
                prev = prev + kg[i];
                sh = s >> (4 * idx);
                if (kd[i] == sh[3:0]) begin
                    idx++;
                    if (idx == el) begin
                        ep = 1; eidx = idx - 1; v = prev; decided = 1;
                    end
                end else begin
                    ef = 1; eidx = idx; v = prev; decided = 1;
                end
            end
        end
        if (!decided) begin
            v = prev + T; ef = 1; eidx = idx;
        end
        while (cyc < v) @(negedge clk);
        chk({tag, "_done"}, 32'(check_done), 1);
        chk({tag, "_pass"}, 32'(pass), 32'(ep));
        chk({tag, "_fail"}, 32'(fail), 32'(ef));
        chk({tag, "_idx"}, 32'(digit_idx), 32'(eidx));
        chk({tag, "_waiting_result"}, 32'(waiting), 0);
        sh = s >> (4 * eidx);
        btn_valid = 1'b1;
        btn_digit = sh[3:0];
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(check_done), 0);
        @(negedge clk);
        btn_valid = 1'b0;
        chk({tag, "_held_pass"}, 32'(pass), 32'(ep));
        chk({tag, "_held_fail"}, 32'(fail), 32'(ef));
        chk({tag, "_held_idx"}, 32'(digit_idx), 32'(eidx));
        chk({tag, "_idle_waiting"}, 32'(waiting), 0);
        chk({tag, "_pulses"}, 32'(done_cnt - b0), 1);
    endtask

    initial begin
        rst = 1'b0; check = 1'b0; btn_valid = 1'b0; btn_digit = '0; cur_lvl = '0; seq_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_waiting", 32'(waiting), 0);
        chk("reset_idx", 32'(digit_idx), 0);
        chk("reset_done", 32'(check_done), 0);
        chk("reset_pass", 32'(pass), 0);
        chk("reset_fail", 32'(fail), 0);
        rst = 1'b1;
        @(negedge clk);

        set_keys(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 10);
        do_check(20'h54321, 3'd5, 5, 0, "full_pass");
        #3 rst = 1'b0;
        #1 chk("reset_clears_pass", 32'(pass), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        set_keys(4'd1, 4'd2, 4'd7, 4'd4, 4'd5, 3);
        do_check(20'h54321, 3'd3, 5, 0, "mismatch");

        set_keys(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 5);
        do_check(20'h54321, 3'd2, 1, 0, "timeout");

        set_keys(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4);
        kg[1] = T;
        do_check(20'h54321, 3'd2, 2, 1, "coincide");

        set_keys(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 2);
        do_check(20'h54321, 3'd0, 5, 0, "lvl0");
        do_check(20'h54321, 3'd7, 5, 0, "lvl7");

        seq_i = 20'h54321; cur_lvl = 3'd5; check = 1'b1;
        @(negedge clk);
        check = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            btn_valid = 1'b1;
            btn_digit = 4'(i);
            @(negedge clk);
            btn_valid = 1'b0;
        end
        base = done_cnt;
        chk("pre_reset_idx", 32'(digit_idx), 2);
        chk("pre_reset_waiting", 32'(waiting), 1);
        #3 rst = 1'b0;
        #1;
        chk("midreset_waiting", 32'(waiting), 0);
        chk("midreset_idx", 32'(digit_idx), 0);
        chk("midreset_done", 32'(check_done), 0);
        chk("midreset_pass", 32'(pass), 0);
        chk("midreset_fail", 32'(fail), 0);
        @(negedge clk);
        @(negedge clk);
        chk("midreset_no_pulse", 32'(done_cnt - base), 0);
        rst = 1'b1;
        @(negedge clk);
        set_keys(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 3);
        do_check(20'h54321, 3'd5, 5, 0, "after_reset");

        for (int n = 0; n < 60; n++) begin
            logic [19:0] s;
            logic [19:0] sh;
            int r, nk;
            s = 20'($urandom);
            nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 5;
            for (int k = 0; k < 5; k++) begin
                sh = s >> (4 * k);
                kd[k] = ($urandom_range(0, 5) == 0) ? sh[3:0] ^ 4'($urandom_range(1, 15)) : sh[3:0];
                r = int'($urandom_range(0, 19));
                kg[k] = (r == 0) ? T + 3 : (r == 1) ? T : int'($urandom_range(1, 12));
            end
            do_check(s, 3'($urandom_range(0, 7)), nk, $urandom_range(0, 4) == 0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
